// File: rtl/frag_commit_fifo_if.sv
// Fragment FIFO bus: traverser write side, consumer read side and status flags.
//   master: drives wr_en/wr_data/wr_last/wr_abort/rd_en, observes read data and status
//   slave : the FIFO itself
interface frag_commit_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_abort;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  threshold;
    logic                  overflow;
    logic                  underflow;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   free;

    modport master (
        output wr_en, wr_data, wr_last, wr_abort, rd_en,
        input  rd_data, rd_valid, full, empty, threshold, overflow, underflow, count, free
    );

    modport slave (
        input  wr_en, wr_data, wr_last, wr_abort, rd_en,
        output rd_data, rd_valid, full, empty, threshold, overflow, underflow, count, free
    );
endinterface

// File: rtl/frag_commit_fifo.sv
// Fragment FIFO with speculative staging: written words become readable only
// once the fragment's last word commits; pending words can be aborted or are
// dropped after an overflow so a partial fragment is never visible.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - frag_commit_fifo_if.slave (write/commit/abort, read, status flags)
module frag_commit_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned THRESHOLD  = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    frag_commit_fifo_if.slave     bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wp;
    logic [PW-1:0]         cp;
    logic [PW-1:0]         rp;
    logic                  drop;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic [PW-1:0] occupied_c;
    logic [PW-1:0] count_c;
    logic          full_c;
    logic          empty_c;
    logic          wr_acc_c;
    logic          wr_rej_c;
    logic          wr_discard_c;
    logic          rd_acc_c;

    // Status derived from the registered pointers
    always_comb begin
        occupied_c = wp - rp;
        count_c    = cp - rp;
        full_c     = (occupied_c == PW'(DEPTH));
        empty_c    = (count_c == '0);
    end

    // Write/read qualification from pre-edge state. A last word that arrives
    // after an overflow, or is itself rejected, throws away the whole fragment.
    always_comb begin
        wr_acc_c     = bus.wr_en & ~full_c & ~bus.wr_abort;
        wr_rej_c     = bus.wr_en &  full_c & ~bus.wr_abort;
        wr_discard_c = bus.wr_en & bus.wr_last & ~bus.wr_abort & (drop | full_c);
        rd_acc_c     = bus.rd_en & ~empty_c;
    end

    // Write side pointers and drop tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp   <= '0;
            cp   <= '0;
            drop <= 1'b0;
        end else if (bus.wr_abort || wr_discard_c) begin
            wp   <= cp;
            drop <= 1'b0;
        end else if (wr_rej_c) begin
            drop <= 1'b1;
        end else if (wr_acc_c) begin
            wp <= wp + PW'(1);
            if (bus.wr_last) begin
                cp <= wp + PW'(1);
            end
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wp[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    // Read side and registered pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rp          <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_valid_q  <= rd_acc_c;
            underflow_q <= bus.rd_en & empty_c;
            overflow_q  <= wr_rej_c & ~wr_discard_c;
            if (rd_acc_c) begin
                rd_data_q <= mem[rp[ADDR_WIDTH-1:0]];
                rp        <= rp + PW'(1);
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.threshold = (occupied_c >= PW'(THRESHOLD));
    assign bus.count     = count_c;
    assign bus.free      = PW'(DEPTH) - occupied_c;
endmodule

// File: doc/frag_commit_fifo.md
# frag_commit_fifo

Parametrised fragment FIFO between the bounding-box traverser and the fragment consumer, replacing the plain word FIFO. Words from the traverser are staged speculatively and become visible to the reader only when the fragment's last word is written (commit). Uncommitted words can be discarded by abort or by overflow, so the consumer never sees a partial fragment. Programmable threshold and occupancy outputs let the traverser stall before overflow.

## Interface
- DATA_WIDTH, 32, width of one attribute word
- ADDR_WIDTH, 6, log2 of depth; DEPTH = 2**ADDR_WIDTH words
- THRESHOLD, 48, `threshold` asserts when occupied words (committed + pending) >= THRESHOLD; legal range 1..DEPTH
- clk  in  1  the single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write `wr_data` as the next pending word
- wr_data  in  DATA_WIDTH  write word
- wr_last  in  1  qualifies `wr_en`: word is the last of its fragment; commit the fragment
- wr_abort  in  1  discard all pending words; independent of `wr_en`
- rd_en  in  1  pop one committed word
- rd_data  out  DATA_WIDTH  registered read word
- rd_valid  out  1  `rd_data` holds a word popped on the previous cycle
- full  out  1  occupied words == DEPTH
- empty  out  1  committed words == 0
- threshold  out  1  see THRESHOLD
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected
- count  out  ADDR_WIDTH+1  committed words available to read
- free  out  ADDR_WIDTH+1  DEPTH minus occupied words

## Operation
- Storage: DEPTH x DATA_WIDTH array. Three pointers, each ADDR_WIDTH+1 bits with a wrap bit: `wp` (pending write), `cp` (commit), `rp` (read). Array index = low ADDR_WIDTH bits. Pointer arithmetic wraps modulo 2**(ADDR_WIDTH+1).
- count = cp - rp; occupied = wp - rp; free = DEPTH - occupied. All flags are combinational from the registered pointers.
- Accepted write (wr_en & !full & !wr_abort): store at wp, wp += 1. With wr_last and no drop flag: cp <= wp + 1 (commit includes this word).
- Abort (wr_abort): wp <= cp; the drop flag clears; any concurrent wr_en word is discarded. Abort takes priority over wr_last and over an accepted write.
- Overflow (wr_en & full & !wr_abort): the word is not stored, `overflow` pulses, and the drop flag is set. While drop is set, writes are still accepted into space. The next wr_last acts as an abort (wp <= cp, drop clears, no commit, no further overflow pulse). This guarantees that a truncated fragment is never committed.
- Accepted read (rd_en & !empty): rd_data <= mem[rp], rp += 1, rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds.
- Rejected read (rd_en & empty): `underflow` pulses; rp unchanged.
- Simultaneous read and write: both use pre-edge state. A write when full is rejected even if a read frees space in the same cycle. A read on the same edge as a commit sees the old count, so a read while empty is rejected even if a commit lands on that edge.
- Abort and wr_last never affect committed words or rp.

## Timing
- Reset (asynchronous, any time including mid-fragment): wp = cp = rp = 0, drop = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0. Hence empty = 1, full = 0, threshold = 0, count = 0, free = DEPTH. Pending and committed data are lost.
- Write-to-visible latency: a word committed at edge N updates count/empty after edge N; the earliest pop is at edge N+1, and rd_valid is high after edge N+1.
- Read latency: 1 cycle (rd_en sampled at edge N; rd_data/rd_valid valid after edge N).
- overflow/underflow are registered pulses, high for exactly the cycle after the offending edge.
- Full throughput: one write and one read per cycle sustained.

## Test plan
- Reset, then write 3 words (0xA0, 0xA1, 0xA2 with wr_last) -> count 0 after words 1-2, count 3 after word 3; pop 3 -> rd_data A0, A1, A2 with rd_valid, then empty = 1.
- Write 2 words, assert wr_abort with a third word -> count stays 0, free returns to DEPTH, the third word is never read.
- DEPTH 16, THRESHOLD 12: write 16 words as one fragment with no wr_last -> threshold at occupancy 12, full at 16. A 17th write -> overflow pulse. Then wr_last -> wp back to cp, free 16, count 0, no commit.
- Fill and drain 40 single-word fragments with concurrent read/write across two wraps -> data order preserved, count never exceeds DEPTH.
- Pop while empty -> underflow pulse one cycle, rd_valid 0. Commit and pop on the same edge -> pop rejected, data is read on the following cycle.
- Assert reset mid-fragment with 5 committed and 3 pending words -> all outputs reach their reset values immediately, and subsequent traffic behaves as after a fresh reset.
